// File: rtl/stereo_cam_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : stereo_cam_pkg                                          |
// | Brief  : Shared types and constants for the stereo camera        |
// |          configuration sequencer.                                |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package stereo_cam_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    RST_ASSERT = 4'd1,
    RST_WAIT   = 4'd2,
    FETCH      = 4'd3,
    DECODE     = 4'd4,
    WRITE      = 4'd5,
    DELAY      = 4'd6,
    DONE       = 4'd7,
    ERROR      = 4'd8
  } cfg_state_t;

  localparam logic CAM_LEFT  = 1'b0;
  localparam logic CAM_RIGHT = 1'b1;

  // Table entry encodings: all-ones ends the table, reg 0xFF is a delay.
  localparam logic [15:0] CFG_END       = 16'hFFFF;
  localparam logic [7:0]  CFG_DELAY_TAG = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/stereo_cam_cfg_seq_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : cam_cfg_timer                                           |
// | Brief  : Loadable down-counter, stops at zero.                   |
// | Rev    : 1.0  initial release                                    |
// | Ports  : clk, rst      clock, synchronous active-high reset      |
// |          load          load load_val this cycle (wins over count)|
// |          load_val[W]   value to load                             |
// |          zero          counter currently reads zero              |
// +------------------------------------------------------------------+
module cam_cfg_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/stereo_cam_cfg_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : stereo_cam_cfg_seq                                      |
// | Brief  : Boot-time sequencer: pulses the sensor reset, then walks|
// |          a ROM register table and writes every entry to each     |
// |          enabled camera through one shared SCCB byte master.     |
// | Rev    : 1.0  initial release                                    |
// | Ports  : start/cam_en      PS control (cam_en sampled on start)  |
// |          rom_addr/rom_data table ROM, data 1 cycle after address |
// |          sccb_*            write request/response handshake      |
// |          cam_rst_n         active-low reset to both sensors      |
// |          busy/done/error   status; err_idx/err_dev locate a fail |
// +------------------------------------------------------------------+
module stereo_cam_cfg_seq
  import stereo_cam_pkg::*;
#(
  parameter  int unsigned NUM_REGS   = 128,
  parameter  int unsigned RST_CYCLES = 100000,
  parameter  int unsigned PWR_CYCLES = 2000000,
  parameter  int unsigned DELAY_UNIT = 100000,
  parameter  int unsigned MAX_RETRY  = 3,
  localparam int          AW         = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    cam_en,
  output logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_data,
  output logic          sccb_req,
  output logic          sccb_dev,
  output logic [7:0]    sccb_reg,
  output logic [7:0]    sccb_dat,
  input  logic          sccb_ack,
  input  logic          sccb_nack,
  output logic          cam_rst_n,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] err_idx,
  output logic          err_dev
);

  // Shared counter must hold the longest of the three waits; the delay
  // product is formed at this width so 255*DELAY_UNIT cannot wrap.
  localparam longint unsigned DLY_MAX  = 64'(DELAY_UNIT) * 64'd255;
  localparam longint unsigned CNT_MAX0 = (64'(PWR_CYCLES) > DLY_MAX) ? 64'(PWR_CYCLES) : DLY_MAX;
  localparam longint unsigned CNT_MAX  = (64'(RST_CYCLES) > CNT_MAX0) ? 64'(RST_CYCLES) : CNT_MAX0;
  localparam int              CW_RAW   = $clog2(CNT_MAX + 64'd1);
  localparam int              CW       = (CW_RAW < 9) ? 9 : CW_RAW;
  localparam int              RW_RAW   = $clog2(MAX_RETRY + 1);
  localparam int              RW       = (RW_RAW < 1) ? 1 : RW_RAW;

  // The counter is loaded on entry to a state and the state exits when it
  // reads zero, so a wait of N cycles loads N-1.
  localparam logic [CW-1:0] RST_LOAD = (RST_CYCLES == 0) ? '0 : CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] PWR_LOAD = (PWR_CYCLES == 0) ? '0 : CW'(PWR_CYCLES - 1);
  localparam logic [CW-1:0] DU_W     = CW'(DELAY_UNIT);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

  cfg_state_t    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    cam_en_q, cam_en_d;
  logic          req_q, req_d;
  logic          dev_q, dev_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    dat_q, dat_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          cam_rst_n_q, cam_rst_n_d;
  logic [AW-1:0] err_idx_q, err_idx_d;
  logic          err_dev_q, err_dev_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_zero;
  logic          advance;
  logic [CW-1:0] dly_prod;

  assign dly_prod = CW'(rom_data[7:0]) * DU_W;

  cam_cfg_timer #(
    .W (CW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cam_en_d    = cam_en_q;
    req_d       = req_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    dat_d       = dat_q;
    retry_d     = retry_q;
    cam_rst_n_d = cam_rst_n_q;
    err_idx_d   = err_idx_q;
    err_dev_d   = err_dev_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    advance     = 1'b0;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d     = RST_ASSERT;
          cam_en_d    = cam_en;
          cam_rst_n_d = 1'b0;
          err_idx_d   = '0;
          err_dev_d   = 1'b0;
          tmr_load    = 1'b1;
          tmr_val     = RST_LOAD;
        end
      end
      RST_ASSERT: begin
        if (tmr_zero) begin
          state_d     = RST_WAIT;
          cam_rst_n_d = 1'b1;
          tmr_load    = 1'b1;
          tmr_val     = PWR_LOAD;
        end
      end
      RST_WAIT: begin
        if (tmr_zero) begin
          state_d = FETCH;
          idx_d   = '0;
        end
      end
      FETCH: begin
        state_d = DECODE;
      end
      DECODE: begin
        if (rom_data == CFG_END) begin
          state_d = DONE;
        end else if (rom_data[15:8] == CFG_DELAY_TAG) begin
          if (rom_data[7:0] == 8'd0) begin
            advance = 1'b1;
          end else begin
            state_d  = DELAY;
            tmr_load = 1'b1;
            tmr_val  = dly_prod - CW'(1);
          end
        end else if (cam_en_q == 2'b00) begin
          advance = 1'b1;
        end else begin
          state_d = WRITE;
          req_d   = 1'b1;
          dev_d   = cam_en_q[0] ? CAM_LEFT : CAM_RIGHT;
          reg_d   = rom_data[15:8];
          dat_d   = rom_data[7:0];
          retry_d = '0;
        end
      end
      WRITE: begin
        // req drops for one cycle after every response; a retry or the
        // second camera re-raises it from here with the payload held.
        if (!req_q) begin
          req_d = 1'b1;
        end else if (sccb_nack) begin
          req_d = 1'b0;
          if (retry_q >= RW'(MAX_RETRY)) begin
            state_d   = ERROR;
            err_idx_d = idx_q;
            err_dev_d = dev_q;
          end else begin
            retry_d = retry_q + RW'(1);
          end
        end else if (sccb_ack) begin
          req_d   = 1'b0;
          retry_d = '0;
          if (dev_q == CAM_LEFT && cam_en_q[1]) begin
            dev_d = CAM_RIGHT;
          end else begin
            advance = 1'b1;
          end
        end
      end
      DELAY: begin
        if (tmr_zero) begin
          advance = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (advance) begin
      if (idx_q == LAST_IDX) begin
        state_d = DONE;
      end else begin
        idx_d   = idx_q + AW'(1);
        state_d = FETCH;
      end
    end

    busy_d  = !(state_d == IDLE || state_d == DONE || state_d == ERROR);
    done_d  = (state_d == DONE);
    error_d = (state_d == ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cam_en_q    <= 2'b00;
      req_q       <= 1'b0;
      dev_q       <= 1'b0;
      reg_q       <= 8'd0;
      dat_q       <= 8'd0;
      retry_q     <= '0;
      cam_rst_n_q <= 1'b1;
      err_idx_q   <= '0;
      err_dev_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cam_en_q    <= cam_en_d;
      req_q       <= req_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      dat_q       <= dat_d;
      retry_q     <= retry_d;
      cam_rst_n_q <= cam_rst_n_d;
      err_idx_q   <= err_idx_d;
      err_dev_q   <= err_dev_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign rom_addr  = idx_q;
  assign sccb_req  = req_q;
  assign sccb_dev  = dev_q;
  assign sccb_reg  = reg_q;
  assign sccb_dat  = dat_q;
  assign cam_rst_n = cam_rst_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_idx   = err_idx_q;
  assign err_dev   = err_dev_q;

endmodule
`default_nettype wire

// File: tb/tb_stereo_cam_cfg_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_stereo_cam_cfg_seq                                   |
// | Brief  : Self-checking bench for stereo_cam_cfg_seq with a       |
// |          registered ROM model and an SCCB responder.             |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module tb_stereo_cam_cfg_seq;

  localparam int NREG = 8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  cam_en;
  logic [2:0]  rom_addr;
  logic [15:0] rom_data;
  logic        sccb_req;
  logic        sccb_dev;
  logic [7:0]  sccb_reg;
  logic [7:0]  sccb_dat;
  logic        sccb_ack;
  logic        sccb_nack;
  logic        cam_rst_n;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  err_idx;
  logic        err_dev;

  stereo_cam_cfg_seq #(
    .NUM_REGS   (8),
    .RST_CYCLES (10),
    .PWR_CYCLES (20),
    .DELAY_UNIT (4),
    .MAX_RETRY  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cam_en    (cam_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .sccb_req  (sccb_req),
    .sccb_dev  (sccb_dev),
    .sccb_reg  (sccb_reg),
    .sccb_dat  (sccb_dat),
    .sccb_ack  (sccb_ack),
    .sccb_nack (sccb_nack),
    .cam_rst_n (cam_rst_n),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_idx   (err_idx),
    .err_dev   (err_dev)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered table ROM: data follows the address by one cycle.
  logic [15:0] rom [NREG];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: logs each request payload {dev,reg,dat} and timing marks.
  logic [16:0] wlog [$];
  int cyc = 0;
  int rst_low = 0;
  int rise_cyc = -1;
  int first_req = -1;
  logic prev_req = 1'b0;
  logic prev_rstn = 1'b1;

  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!cam_rst_n) rst_low++;
      if (cam_rst_n && !prev_rstn) rise_cyc = cyc;
      if (sccb_req && !prev_req) begin
        wlog.push_back({sccb_dev, sccb_reg, sccb_dat});
        if (first_req < 0) first_req = cyc;
      end
      prev_req  = sccb_req;
      prev_rstn = cam_rst_n;
    end
  end

  // Responder: answers a request on its third clock, nacking first.
  logic resp_en = 1'b1;
  int   nacks_left = 0;

  initial begin
    sccb_ack  = 1'b0;
    sccb_nack = 1'b0;
    forever begin
      @(posedge clk); #2;
      sccb_ack  = 1'b0;
      sccb_nack = 1'b0;
      if (resp_en && sccb_req) begin
        repeat (2) begin @(posedge clk); #2; end
        if (nacks_left > 0) begin
          sccb_nack = 1'b1;
          nacks_left--;
        end else begin
          sccb_ack = 1'b1;
        end
      end
    end
  end

  task automatic clear_mon();
    wlog.delete();
    rst_low   = 0;
    rise_cyc  = -1;
    first_req = -1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int c = 0;
    while (busy && c < lim) begin @(posedge clk); #1; c++; end
    chk(nm, 32'(busy), 32'd0);
  endtask

  task automatic wait_req(input string nm, input int lim);
    int c = 0;
    while (!sccb_req && c < lim) begin @(posedge clk); #1; c++; end
    chk(nm, 32'(sccb_req), 32'd1);
  endtask

  typedef struct {
    logic [7:0][15:0] rom;
    logic [1:0]       cam_en;
    int               nacks;
    int               exp_n;
    logic [7:0][16:0] exp_w;
    logic             exp_done;
    logic             exp_err;
    logic [2:0]       exp_eidx;
    logic             exp_edev;
    int               exp_lat;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    cam_en = 2'b00;
    for (int i = 0; i < NREG; i++) rom[i] = 16'hFFFF;

    for (int v = 0; v < NV; v++) begin
      vecs[v].rom      = {8{16'hFFFF}};
      vecs[v].cam_en   = 2'b11;
      vecs[v].nacks    = 0;
      vecs[v].exp_n    = 0;
      vecs[v].exp_w    = '0;
      vecs[v].exp_done = 1'b1;
      vecs[v].exp_err  = 1'b0;
      vecs[v].exp_eidx = 3'd0;
      vecs[v].exp_edev = 1'b0;
      vecs[v].exp_lat  = -1;
    end
    // 0: sanity, both cameras, writes interleave L/R per entry
    vecs[0].rom[0] = 16'h1280; vecs[0].rom[1] = 16'h1100;
    vecs[0].exp_n  = 4;
    vecs[0].exp_w[0] = {1'b0, 16'h1280}; vecs[0].exp_w[1] = {1'b1, 16'h1280};
    vecs[0].exp_w[2] = {1'b0, 16'h1100}; vecs[0].exp_w[3] = {1'b1, 16'h1100};
    vecs[0].exp_lat = 22;
    // 1: delay entry of 5 units (20 cycles) before a left-only write
    vecs[1].rom[0] = 16'hFF05; vecs[1].rom[1] = 16'h3A04;
    vecs[1].cam_en = 2'b01;
    vecs[1].exp_n  = 1; vecs[1].exp_w[0] = {1'b0, 16'h3A04};
    vecs[1].exp_lat = 44;
    // 2: two nacks then ack -> three identical requests
    vecs[2].rom[0] = 16'h1280; vecs[2].cam_en = 2'b01; vecs[2].nacks = 2;
    vecs[2].exp_n  = 3;
    for (int i = 0; i < 3; i++) vecs[2].exp_w[i] = {1'b0, 16'h1280};
    vecs[2].exp_lat = 22;
    // 3: no end mark, right camera only, zero-length delay at idx 2
    for (int i = 0; i < NREG; i++) vecs[3].rom[i] = {8'(i + 1), 8'(i + 1)};
    vecs[3].rom[2] = 16'hFF00;
    vecs[3].cam_en = 2'b10;
    vecs[3].exp_n  = 7;
    vecs[3].exp_w[0] = {1'b1, 16'h0101}; vecs[3].exp_w[1] = {1'b1, 16'h0202};
    vecs[3].exp_w[2] = {1'b1, 16'h0404}; vecs[3].exp_w[3] = {1'b1, 16'h0505};
    vecs[3].exp_w[4] = {1'b1, 16'h0606}; vecs[3].exp_w[5] = {1'b1, 16'h0707};
    vecs[3].exp_w[6] = {1'b1, 16'h0808};
    // 4: no camera enabled -> no requests, delay still walked
    vecs[4].rom[0] = 16'h1280; vecs[4].rom[1] = 16'hFF02; vecs[4].rom[2] = 16'h1100;
    vecs[4].cam_en = 2'b00;
    // 5: three nacks on the first write -> error at idx 0, left
    vecs[5].rom[0] = 16'h1280; vecs[5].rom[1] = 16'h1100; vecs[5].nacks = 3;
    vecs[5].exp_n  = 3;
    for (int i = 0; i < 3; i++) vecs[5].exp_w[i] = {1'b0, 16'h1280};
    vecs[5].exp_done = 1'b0; vecs[5].exp_err = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",       32'(sccb_req),  32'd0);
    chk("rst_cam_rst_n", 32'(cam_rst_n), 32'd1);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_error",     32'(error),     32'd0);
    chk("rst_err_idx",   32'(err_idx),   32'd0);
    chk("rst_rom_addr",  32'(rom_addr),  32'd0);
    rst = 1'b0;

    for (int v = 0; v < NV; v++) begin
      for (int i = 0; i < NREG; i++) rom[i] = vecs[v].rom[i];
      cam_en     = vecs[v].cam_en;
      nacks_left = vecs[v].nacks;
      clear_mon();
      pulse_start();
      wait_idle($sformatf("v%0d_timeout", v), 4000);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done", v),    32'(done),  32'(vecs[v].exp_done));
      chk($sformatf("v%0d_error", v),   32'(error), 32'(vecs[v].exp_err));
      chk($sformatf("v%0d_rst_low", v), 32'(rst_low), 32'd10);
      chk($sformatf("v%0d_nreq", v),    32'(wlog.size()), 32'(vecs[v].exp_n));
      for (int i = 0; i < vecs[v].exp_n && i < wlog.size(); i++)
        chk($sformatf("v%0d_write%0d", v, i), 32'(wlog[i]), 32'(vecs[v].exp_w[i]));
      if (vecs[v].exp_err) begin
        chk($sformatf("v%0d_err_idx", v), 32'(err_idx), 32'(vecs[v].exp_eidx));
        chk($sformatf("v%0d_err_dev", v), 32'(err_dev), 32'(vecs[v].exp_edev));
      end
      if (vecs[v].exp_lat >= 0)
        chk($sformatf("v%0d_latency", v), 32'(first_req - rise_cyc), 32'(vecs[v].exp_lat));
    end

    // Start after ERROR: status clears at once and the full sequence reruns
    rom[0] = 16'h1280; rom[1] = 16'hFFFF;
    cam_en = 2'b01; nacks_left = 0;
    clear_mon();
    pulse_start();
    chk("rerun_error_clr", 32'(error), 32'd0);
    chk("rerun_busy",      32'(busy),  32'd1);
    wait_idle("rerun_timeout", 4000);
    chk("rerun_done",    32'(done),    32'd1);
    chk("rerun_rst_low", 32'(rst_low), 32'd10);
    chk("rerun_nreq",    32'(wlog.size()), 32'd1);

    // start pulsed while a write is outstanding is ignored
    clear_mon();
    pulse_start();
    wait_req("sw_req_timeout", 200);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("sw_timeout", 4000);
    chk("sw_done",    32'(done),    32'd1);
    chk("sw_rst_low", 32'(rst_low), 32'd10);
    chk("sw_nreq",    32'(wlog.size()), 32'd1);

    // Reset while a request is up drops it on the next edge
    resp_en = 1'b0;
    clear_mon();
    pulse_start();
    wait_req("rr_req_timeout", 200);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rr_req",       32'(sccb_req),  32'd0);
    chk("rr_cam_rst_n", 32'(cam_rst_n), 32'd1);
    chk("rr_busy",      32'(busy),      32'd0);
    chk("rr_done",      32'(done),      32'd0);
    rst = 1'b0;
    resp_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rr_stays_idle", 32'(busy | sccb_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
